// File: rtl/mano_pkg.sv
// rtl/mano_pkg.sv - shared ALU codes, opcodes, sequencer states and register-reference decode helpers
package mano_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_LDA  = 4'b0010;
  localparam logic [3:0] ALU_CMA  = 4'b0011;
  localparam logic [3:0] ALU_CIR  = 4'b0100;
  localparam logic [3:0] ALU_CIL  = 4'b0101;
  localparam logic [3:0] ALU_CLA  = 4'b0110;
  localparam logic [3:0] ALU_INC  = 4'b0111;
  localparam logic [3:0] ALU_CLE  = 4'b1000;
  localparam logic [3:0] ALU_CME  = 4'b1001;
  localparam logic [3:0] ALU_SPA  = 4'b1010;
  localparam logic [3:0] ALU_SNA  = 4'b1011;
  localparam logic [3:0] ALU_SZA  = 4'b1100;
  localparam logic [3:0] ALU_SZE  = 4'b1101;
  localparam logic [3:0] ALU_IDLE = 4'b1110;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IO  = 3'd7;

  localparam int RB_CLA = 11;
  localparam int RB_CLE = 10;
  localparam int RB_CMA = 9;
  localparam int RB_CME = 8;
  localparam int RB_CIR = 7;
  localparam int RB_CIL = 6;
  localparam int RB_INC = 5;
  localparam int RB_SPA = 4;
  localparam int RB_SNA = 3;
  localparam int RB_SZA = 2;
  localparam int RB_SZE = 1;
  localparam int RB_HLT = 0;

  typedef enum logic [2:0] {FETCH, DECODE, INDIRECT, OPER, EXEC, REGOP, HALT} state_e;

  // Highest set register-reference bit among 11..1; 0 when none remain.
  function automatic logic [3:0] msb_idx(input logic [11:1] v);
    msb_idx = 4'd0;
    for (int i = 1; i < 12; i++) begin
      if (v[i]) msb_idx = 4'(i);
    end
  endfunction

  function automatic logic [3:0] reg_code(input logic [3:0] idx);
    case (int'(idx))
      RB_CLA:  reg_code = ALU_CLA;
      RB_CLE:  reg_code = ALU_CLE;
      RB_CMA:  reg_code = ALU_CMA;
      RB_CME:  reg_code = ALU_CME;
      RB_CIR:  reg_code = ALU_CIR;
      RB_CIL:  reg_code = ALU_CIL;
      RB_INC:  reg_code = ALU_INC;
      RB_SPA:  reg_code = ALU_SPA;
      RB_SNA:  reg_code = ALU_SNA;
      RB_SZA:  reg_code = ALU_SZA;
      RB_SZE:  reg_code = ALU_SZE;
      default: reg_code = ALU_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mano_mem_if.sv
// rtl/mano_mem_if.sv - req/ack handshake holder: issues one transaction, holds it until ack, pulses done
module mano_mem_if #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic          done_o,
  output logic [15:0]   rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [15:0]   mem_wdata_o,
  input  logic [15:0]   mem_rdata_i,
  input  logic          mem_ack_i
);

  logic          req_q, req_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;

  // Start is ignored while a request is open, so the ack edge always leaves one idle cycle.
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (req_q) begin
      if (mem_ack_i) req_d = 1'b0;
    end else if (start_i) begin
      req_d   = 1'b1;
      we_d    = we_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign done_o      = req_q & mem_ack_i;
  assign rdata_o     = mem_rdata_i;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mano_ctrl_seq.sv
// rtl/mano_ctrl_seq.sv - Mano basic-computer sequencer feeding the 16-bit ALU; optional MANO_CTRL_SEQ_STEP_EN single-step gate
module mano_ctrl_seq
  import mano_pkg::*;
#(
  parameter int            AW     = 12,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef MANO_CTRL_SEQ_STEP_EN
  input  logic          step,
`endif
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [3:0]    alu_code,
  output logic [15:0]   alu_ac,
  output logic [15:0]   alu_dr,
  output logic          alu_ei,
  input  logic [15:0]   alu_data,
  input  logic          alu_eo,
  input  logic          alu_inc,
  output logic          halt
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, ar_q, ar_d;
  logic [15:0]   ir_q, ir_d, ac_q, ac_d, dr_q, dr_d;
  logic          e_q, e_d, phase_q, phase_d, skip_q, skip_d;
  logic [11:0]   rem_q, rem_d;
  logic          mem_start, mem_wr, mem_done, fetch_ok, skip_now;
  logic [AW-1:0] mem_a;
  logic [15:0]   mem_wd, mem_rd;
  logic [3:0]    bit_idx;
  logic [2:0]    op;

  assign op      = ir_q[14:12];
  assign bit_idx = msb_idx(rem_q[11:1]);
  assign alu_ac  = ac_q;
  assign alu_dr  = dr_q;
  assign alu_ei  = e_q;
  assign halt    = (state_q == HALT);

`ifdef MANO_CTRL_SEQ_STEP_EN
  logic step_prev_q, step_pend_q, step_pend_d;
  // One pending step at most; it is consumed when FETCH actually opens its request.
  assign step_pend_d = (step & ~step_prev_q) |
                       (step_pend_q & ~(state_q == FETCH && !mem_req));
  assign fetch_ok    = step_pend_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_prev_q <= step;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign fetch_ok = 1'b1;
`endif

  mano_mem_if #(.AW(AW)) u_mem_if (
    .clk_i(clk), .rst_ni(rst_n), .start_i(mem_start), .we_i(mem_wr),
    .addr_i(mem_a), .wdata_i(mem_wd), .done_o(mem_done), .rdata_o(mem_rd),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  always_comb begin
    state_d = state_q; pc_d = pc_q; ar_d = ar_q; ir_d = ir_q;
    ac_d = ac_q; dr_d = dr_q; e_d = e_q;
    phase_d = phase_q; skip_d = skip_q; rem_d = rem_q;
    mem_start = 1'b0; mem_wr = 1'b0; mem_a = ar_q; mem_wd = ac_q;
    alu_code = ALU_IDLE; skip_now = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_start = fetch_ok;
        mem_a     = pc_q;
        if (mem_done) begin
          ir_d = mem_rd; ar_d = mem_rd[AW-1:0]; pc_d = pc_q + AW'(1); state_d = DECODE;
        end
      end
      DECODE: begin
        rem_d = ir_q[11:0]; skip_d = 1'b0; phase_d = 1'b0;
        if (op == OP_IO) state_d = ir_q[15] ? FETCH : REGOP;
        else             state_d = ir_q[15] ? INDIRECT : OPER;
      end
      INDIRECT: begin
        mem_start = 1'b1;
        if (mem_done) begin
          ar_d = mem_rd[AW-1:0]; state_d = OPER;
        end
      end
      OPER: begin
        case (op)
          OP_AND, OP_ADD, OP_LDA: begin
            mem_start = 1'b1;
            if (mem_done) begin
              dr_d = mem_rd; state_d = EXEC;
            end
          end
          OP_STA: begin
            mem_start = 1'b1; mem_wr = 1'b1;
            if (mem_done) state_d = FETCH;
          end
          OP_BUN: begin
            pc_d = ar_q; state_d = FETCH;
          end
          OP_BSA: begin
            mem_start = 1'b1; mem_wr = 1'b1; mem_wd = 16'(pc_q);
            if (mem_done) begin
              pc_d = ar_q + AW'(1); state_d = FETCH;
            end
          end
          OP_ISZ: begin
            // Phase 0 reads and increments into DR, phase 1 writes DR back.
            mem_start = 1'b1; mem_wr = phase_q; mem_wd = dr_q;
            if (mem_done && !phase_q) begin
              dr_d = mem_rd + 16'd1; phase_d = 1'b1;
            end else if (mem_done) begin
              if (dr_q == 16'd0) pc_d = pc_q + AW'(1);
              phase_d = 1'b0; state_d = FETCH;
            end
          end
          default: state_d = FETCH;
        endcase
      end
      EXEC: begin
        alu_code = {1'b0, op};
        ac_d     = alu_data;
        if (op == OP_ADD) e_d = alu_eo;
        state_d  = FETCH;
      end
      REGOP: begin
        if (rem_q[11:1] != 11'd0) begin
          alu_code = reg_code(bit_idx);
          rem_d    = rem_q & ~(12'd1 << bit_idx);
          if (alu_code inside {ALU_CMA, ALU_CIR, ALU_CIL, ALU_CLA, ALU_INC}) ac_d = alu_data;
          if (alu_code inside {ALU_CIR, ALU_CIL, ALU_CLE, ALU_CME}) e_d = alu_eo;
          skip_now = alu_inc && (alu_code inside {ALU_SPA, ALU_SNA, ALU_SZA, ALU_SZE});
        end
        skip_d = skip_q | skip_now;
        // Scan ends in the cycle that retires the last set bit (or the lone NOP/HLT cycle).
        if (rem_d[11:1] == 11'd0) begin
          if (skip_d) pc_d = pc_q + AW'(1);
          state_d = rem_q[0] ? HALT : FETCH;
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH; pc_q <= RST_PC; ar_q <= '0; ir_q <= '0;
      ac_q <= '0; dr_q <= '0; e_q <= 1'b0;
      phase_q <= 1'b0; skip_q <= 1'b0; rem_q <= '0;
    end else begin
      state_q <= state_d; pc_q <= pc_d; ar_q <= ar_d; ir_q <= ir_d;
      ac_q <= ac_d; dr_q <= dr_d; e_q <= e_d;
      phase_q <= phase_d; skip_q <= skip_d; rem_q <= rem_d;
    end
  end

endmodule
